amo_sequencer: RTL

//  Multi-cycle read-modify-write sequencer for RV32A (LR.W, SC.W, AMO*.W), placed beside the ALU decoder.
//  It drives AMOop into the decoder, feeds ALU operands, and consumes the ALU result.
//  It owns the LR/SC reservation and runs the word-aligned load/modify/store handshake to memory.

---
 rtl/amo_sequencer_pkg.sv | 29 ++
 rtl/amo_sequencer_reservation.sv | 51 +++++
 rtl/amo_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/amo_sequencer_pkg.sv
// Shared types and constants for the RV32A atomic sequencer.
package amo_sequencer_pkg;

    localparam int AMO_XLEN     = 32;
    localparam int AMO_RESV_LSB = 2;
    localparam int AMO_OP_WIDTH = 4;

    // Atomic operation codes driven into the ALU decoder
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_LR   = 4'd0;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_SC   = 4'd1;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_SWAP = 4'd2;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_ADD  = 4'd3;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_XOR  = 4'd4;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_AND  = 4'd5;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_OR   = 4'd6;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MIN  = 4'd7;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MAX  = 4'd8;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MINU = 4'd9;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MAXU = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MODIFY = 3'd2,
        ST_STORE  = 3'd3,
        ST_DONE   = 3'd4
    } amo_state_t;

endpackage

// File: rtl/amo_sequencer_reservation.sv
// LR/SC reservation: one valid bit plus the reserved word tag.
// Clearing sources always beat a same-cycle set.
module amo_reservation
    import amo_sequencer_pkg::*;
#(
    parameter int TAG_W = AMO_XLEN - AMO_RESV_LSB
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             set_en,
    input  logic [TAG_W-1:0] set_tag,
    input  logic [TAG_W-1:0] chk_tag,
    input  logic             sc_exec,
    input  logic             store_exec,
    input  logic             resv_clear,
    output logic             sc_ok
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             match;

    assign match = valid_q && (tag_q == chk_tag);
    // An external clear arriving with the SC check makes the SC fail
    assign sc_ok = match && !resv_clear;

    // Next reservation: set by LR, then any clearing source overrides it
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (set_en) begin
            valid_d = 1'b1;
            tag_d   = set_tag;
        end
        if (sc_exec || (store_exec && match) || resv_clear) begin
            valid_d = 1'b0;
        end
    end

    // Reservation register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: rtl/amo_sequencer.sv
// Multi-cycle read-modify-write sequencer for LR.W / SC.W / AMO*.W.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | word read outstanding on the memory port
// MODIFY | one cycle: ALU (or local max / rs2) forms the store word
// STORE  | word write outstanding on the memory port
// DONE   | one-cycle completion pulse with rd_data
module amo_sequencer
    import amo_sequencer_pkg::*;
#(
    parameter int XLEN     = AMO_XLEN,
    parameter int RESV_LSB = AMO_RESV_LSB
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [AMO_OP_WIDTH-1:0] amo_op,
    input  logic [XLEN-1:0]         addr,
    input  logic [XLEN-1:0]         rs2,
    input  logic                    resv_clear,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    mem_wr,
    output logic [XLEN-1:0]         mem_addr,
    output logic [XLEN-1:0]         mem_wdata,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic [AMO_OP_WIDTH-1:0] AMOop,
    output logic [XLEN-1:0]         alu_a,
    output logic [XLEN-1:0]         alu_b,
    input  logic [XLEN-1:0]         alu_result,
    output logic [XLEN-1:0]         rd_data,
    output logic                    done,
    output logic                    busy,
    output logic                    misaligned
);

    localparam int TAG_W = XLEN - RESV_LSB;
    localparam int WA_W  = XLEN - 2;

    amo_state_t              state_q, state_d;
    logic [AMO_OP_WIDTH-1:0] op_q, op_d;
    logic [WA_W-1:0]         waddr_q, waddr_d;
    logic [XLEN-1:0]         rs2_q, rs2_d;
    logic [XLEN-1:0]         load_q, load_d;
    logic [XLEN-1:0]         store_q, store_d;
    logic [XLEN-1:0]         rd_q, rd_d;
    logic                    misal_q, misal_d;

    logic             accept;
    logic             aligned;
    logic             sc_ok;
    logic             sc_exec;
    logic             set_en;
    logic             store_exec;
    logic [TAG_W-1:0] cur_tag;
    logic [TAG_W-1:0] chk_tag;
    logic [XLEN-1:0]  max_val;

    assign accept  = (state_q == ST_IDLE) && start;
    assign aligned = (addr[1:0] == 2'b00);
    assign cur_tag = waddr_q[WA_W-1:RESV_LSB-2];
    // In IDLE the SC check needs the incoming address; later phases use the latched one
    assign chk_tag = (state_q == ST_IDLE) ? addr[XLEN-1:RESV_LSB] : cur_tag;

    assign sc_exec    = accept && aligned && (amo_op == AMO_OP_SC);
    assign set_en     = (state_q == ST_LOAD) && mem_ready && (op_q == AMO_OP_LR);
    assign store_exec = (state_q == ST_STORE) && mem_ready && (op_q != AMO_OP_SC);

    // MAX.W is resolved here rather than by the shared ALU
    assign max_val = ($signed(load_q) > $signed(rs2_q)) ? load_q : rs2_q;

    amo_reservation #(
        .TAG_W (TAG_W)
    ) u_resv (
        .clk        (clk),
        .resetn     (resetn),
        .set_en     (set_en),
        .set_tag    (cur_tag),
        .chk_tag    (chk_tag),
        .sc_exec    (sc_exec),
        .store_exec (store_exec),
        .resv_clear (resv_clear),
        .sc_ok      (sc_ok)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!aligned) begin
                        state_d = ST_DONE;
                    end else if (amo_op == AMO_OP_SC) begin
                        state_d = sc_ok ? ST_STORE : ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (mem_ready) begin
                    state_d = (op_q == AMO_OP_LR) ? ST_DONE : ST_MODIFY;
                end
            end
            ST_MODIFY: state_d = ST_STORE;
            ST_STORE: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath register updates: operand capture, load data, store word, result
    always_comb begin
        op_d    = op_q;
        waddr_d = waddr_q;
        rs2_d   = rs2_q;
        load_d  = load_q;
        store_d = store_q;
        rd_d    = rd_q;
        misal_d = misal_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = amo_op;
                    waddr_d = addr[XLEN-1:2];
                    rs2_d   = rs2;
                    misal_d = !aligned;
                    // SC goes straight to STORE, so its store word is rs2 right away
                    store_d = rs2;
                    rd_d    = '0;
                    if (aligned && (amo_op == AMO_OP_SC) && !sc_ok) begin
                        rd_d = {{(XLEN-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_LOAD: begin
                if (mem_ready) begin
                    load_d = mem_rdata;
                    rd_d   = mem_rdata;
                end
            end
            ST_MODIFY: begin
                case (op_q)
                    AMO_OP_SWAP, AMO_OP_SC: store_d = rs2_q;
                    AMO_OP_MAX:             store_d = max_val;
                    default:                store_d = alu_result;
                endcase
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q    <= '0;
            waddr_q <= '0;
            rs2_q   <= '0;
            load_q  <= '0;
            store_q <= '0;
            rd_q    <= '0;
            misal_q <= 1'b0;
        end else begin
            op_q    <= op_d;
            waddr_q <= waddr_d;
            rs2_q   <= rs2_d;
            load_q  <= load_d;
            store_q <= store_d;
            rd_q    <= rd_d;
            misal_q <= misal_d;
        end
    end

    // State-decoded outputs; memory fields come from registers so they hold while stalled
    always_comb begin
        mem_valid  = 1'b0;
        mem_wr     = 1'b0;
        done       = 1'b0;
        rd_data    = '0;
        misaligned = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_LOAD:  mem_valid = 1'b1;
            ST_STORE: begin
                mem_valid = 1'b1;
                mem_wr    = 1'b1;
            end
            ST_DONE: begin
                done       = 1'b1;
                rd_data    = rd_q;
                misaligned = misal_q;
            end
            default: ;
        endcase
    end

    assign mem_addr  = {waddr_q, 2'b00};
    assign mem_wdata = store_q;
    assign AMOop     = op_q;
    assign alu_a     = load_q;
    assign alu_b     = rs2_q;

endmodule
